// File: rtl/flash_audio_pkg.sv
// Shared types and defaults for the flash audio sample reader.
package flash_audio_pkg;
  localparam int ADDR_W = 23;
  localparam logic [ADDR_W-1:0] DEF_START_ADDR = 23'h000000;
  localparam logic [ADDR_W-1:0] DEF_END_ADDR   = 23'h07FFFF;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, HOLD} state_t;
endpackage

// File: rtl/addr_wrap_counter.sv
// Word-address counter with load, and up/down stepping that wraps inside [LO, HI].
module addr_wrap_counter #(
  parameter int           W  = 23,
  parameter logic [W-1:0] LO = '0,
  parameter logic [W-1:0] HI = '1
) (
  input  logic         CLK_50M,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);
  always_ff @(posedge CLK_50M) begin
    if (!reset)
      count <= LO;
    else if (load)
      count <= load_val;
    else if (step) begin
      if (down) count <= (count == LO) ? HI : count - 1'b1;
      else      count <= (count == HI) ? LO : count + 1'b1;
    end
  end
endmodule

// File: rtl/flash_audio_reader.sv
// Streams 16-bit audio samples out of 32-bit flash words over Avalon-MM,
// two samples per word, forward or backward through a wrapping region.
import flash_audio_pkg::*;

module flash_audio_reader #(
  parameter int                ADDR_W     = flash_audio_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = flash_audio_pkg::DEF_START_ADDR,
  parameter logic [ADDR_W-1:0] END_ADDR   = flash_audio_pkg::DEF_END_ADDR
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              play,
  input  logic              reverse,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_mem_read,
  input  logic              flash_mem_waitrequest,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid
);
  state_t      state;
  logic        dir;
  logic        restart_pend;
  logic [15:0] second_half;
  logic        cnt_load, cnt_step;

  // HOLD only consumes a tick once the first-half pulse has dropped,
  // so audio_valid can never stay high across two cycles.
  logic hold_adv;
  assign hold_adv = sample_tick && play && !audio_valid;

  always_comb begin
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    case (state)
      IDLE:      cnt_load = restart;
      HOLD: begin
        cnt_load = restart;
        cnt_step = !restart && hold_adv;
      end
      WAIT_DATA: cnt_load = flash_mem_readdatavalid && (restart_pend || restart);
      default: ;
    endcase
  end

  addr_wrap_counter #(.W(ADDR_W), .LO(START_ADDR), .HI(END_ADDR)) u_addr (
    .CLK_50M  (CLK_50M),
    .reset    (reset),
    .load     (cnt_load),
    .step     (cnt_step),
    .down     (dir),
    .load_val (reverse ? END_ADDR : START_ADDR),
    .count    (flash_mem_address)
  );

  assign flash_mem_byteenable = 4'hF;

  always_ff @(posedge CLK_50M) begin
    if (!reset) begin
      state          <= IDLE;
      dir            <= 1'b0;
      restart_pend   <= 1'b0;
      second_half    <= 16'h0000;
      flash_mem_read <= 1'b0;
      audio_data     <= 16'h0000;
      audio_valid    <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      case (state)
        IDLE: if (!restart && sample_tick && play) begin
          dir            <= reverse;
          flash_mem_read <= 1'b1;
          state          <= REQ;
        end
        REQ: begin
          if (restart) restart_pend <= 1'b1;
          if (!flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            state          <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flash_mem_readdatavalid) begin
            if (restart_pend || restart) begin
              restart_pend <= 1'b0;
              state        <= IDLE;
            end else begin
              audio_data  <= dir ? flash_mem_readdata[31:16] : flash_mem_readdata[15:0];
              second_half <= dir ? flash_mem_readdata[15:0]  : flash_mem_readdata[31:16];
              audio_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (restart) begin
            restart_pend <= 1'b1;
          end
        end
        HOLD: begin
          if (restart)
            state <= IDLE;
          else if (hold_adv) begin
            audio_data  <= second_half;
            audio_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flash_audio_reader.sv
// Bench for flash_audio_reader: Avalon flash slave model plus sample/address scoreboards.
module tb_flash_audio_reader;
  localparam int          NW = 8;
  localparam logic [22:0] S  = 23'h0;
  localparam logic [22:0] E  = 23'h7;

  logic        CLK_50M = 1'b0;
  logic        reset = 1'b0, play = 1'b0, reverse = 1'b0, restart = 1'b0, sample_tick = 1'b0;
  logic        flash_mem_read, flash_mem_waitrequest = 1'b1;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata = 32'h0;
  logic        flash_mem_readdatavalid = 1'b0;
  logic [15:0] audio_data;
  logic        audio_valid;

  flash_audio_reader #(.ADDR_W(23), .START_ADDR(S), .END_ADDR(E)) dut (
    .CLK_50M(CLK_50M), .reset(reset), .play(play), .reverse(reverse), .restart(restart),
    .sample_tick(sample_tick), .flash_mem_read(flash_mem_read),
    .flash_mem_waitrequest(flash_mem_waitrequest), .flash_mem_address(flash_mem_address),
    .flash_mem_byteenable(flash_mem_byteenable), .flash_mem_readdata(flash_mem_readdata),
    .flash_mem_readdatavalid(flash_mem_readdatavalid), .audio_data(audio_data),
    .audio_valid(audio_valid)
  );

  always #10 CLK_50M = ~CLK_50M;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] mem [NW];
  int wait_cfg = 0, lat_cfg = 1, wcnt = 0, lcnt = 0, inj_req = 0, inj_done = 0;
  bit pend_s = 1'b0;
  logic [22:0] paddr;
  logic [22:0] addrq [$];
  logic [15:0] got [$];
  int rd_cycles = 0, dbl_valid = 0;
  logic prev_v = 1'b0;

  // Flash slave: wait_cfg stall cycles per read, lat_cfg cycles to readdatavalid.
  always @(negedge CLK_50M) begin
    flash_mem_readdatavalid = 1'b0;
    if (!reset) begin
      wcnt = 0; pend_s = 1'b0;
    end else begin
      if (inj_req != inj_done) begin
        inj_done = inj_req;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hFFFF_0000;
      end else if (pend_s) begin
        if (lcnt == 0) begin
          flash_mem_readdatavalid = 1'b1;
          flash_mem_readdata = mem[paddr[2:0]];
          pend_s = 1'b0;
        end else lcnt--;
      end
      if (flash_mem_read && !pend_s) begin
        if (wcnt < wait_cfg) begin
          flash_mem_waitrequest = 1'b1; wcnt++;
        end else begin
          flash_mem_waitrequest = 1'b0; wcnt = 0; pend_s = 1'b1;
          lcnt = lat_cfg - 1; paddr = flash_mem_address;
          addrq.push_back(flash_mem_address);
        end
      end
    end
  end

  always @(negedge CLK_50M) begin
    if (flash_mem_read) rd_cycles++;
    if (audio_valid) got.push_back(audio_data);
    if (audio_valid && prev_v) dbl_valid++;
    prev_v = audio_valid;
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK_50M);
  endtask

  task automatic tick();
    @(negedge CLK_50M); sample_tick = 1'b1;
    @(negedge CLK_50M); sample_tick = 1'b0;
  endtask

  task automatic restart_pulse();
    @(negedge CLK_50M); restart = 1'b1;
    @(negedge CLK_50M); restart = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK_50M);
    reset = 1'b0; play = 1'b0; reverse = 1'b0; restart = 1'b0; sample_tick = 1'b0;
    wait_cfg = 0; lat_cfg = 1;
    step(3);
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_read_low();
    int k = 0;
    while (flash_mem_read && k < 50) begin step(1); k++; end
    n_cmp++;
    if (flash_mem_read) begin n_bad++; $display("FAIL read_timeout: read still high after %0d cycles", k); end
  endtask

  task automatic test_reset();
    @(negedge CLK_50M);
    reset = 1'b0; step(2);
    n_cmp++; if (flash_mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b want 0", flash_mem_read); end
    n_cmp++; if (audio_data !== 16'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0000", audio_data); end
    n_cmp++; if (audio_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", audio_valid); end
    n_cmp++; if (flash_mem_address !== S) begin n_bad++; $display("FAIL rst_addr: got %h want %h", flash_mem_address, S); end
    n_cmp++; if (flash_mem_byteenable !== 4'hF) begin n_bad++; $display("FAIL byteenable: got %h want F", flash_mem_byteenable); end
    reset = 1'b1; step(1);
  endtask

  task automatic test_forward();
    logic [15:0] exp [4];
    int g0, a0;
    do_reset();
    mem[0] = 32'hBBBB_AAAA; mem[1] = 32'hDDDD_CCCC;
    exp[0] = 16'hAAAA; exp[1] = 16'hBBBB; exp[2] = 16'hCCCC; exp[3] = 16'hDDDD;
    play = 1'b1; reverse = 1'b0; wait_cfg = 1; lat_cfg = 2;
    g0 = got.size(); a0 = addrq.size();
    repeat (4) begin tick(); step(12); end
    n_cmp++;
    if (got.size() != g0 + 4) begin n_bad++; $display("FAIL fwd_count: got %0d want 4", got.size() - g0); end
    else for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[g0+i] !== exp[i]) begin n_bad++; $display("FAIL fwd_sample%0d: got %h want %h", i, got[g0+i], exp[i]); end
    end
    n_cmp++;
    if (addrq.size() != a0 + 2) begin n_bad++; $display("FAIL fwd_nreads: got %0d want 2", addrq.size() - a0); end
    else begin
      n_cmp++; if (addrq[a0] !== 23'd0) begin n_bad++; $display("FAIL fwd_addr0: got %h want 0", addrq[a0]); end
      n_cmp++; if (addrq[a0+1] !== 23'd1) begin n_bad++; $display("FAIL fwd_addr1: got %h want 1", addrq[a0+1]); end
    end
  endtask

  task automatic test_reverse_wrap();
    int g0, a0;
    do_reset();
    mem[0] = 32'h1234_5678;
    play = 1'b1; reverse = 1'b1;
    g0 = got.size(); a0 = addrq.size();
    tick(); step(10); tick(); step(4); tick(); step(10); tick(); step(4);
    n_cmp++;
    if (got.size() < g0 + 2) begin n_bad++; $display("FAIL rev_count: got %0d want >=2", got.size() - g0); end
    else begin
      n_cmp++; if (got[g0] !== 16'h1234) begin n_bad++; $display("FAIL rev_first: got %h want 1234", got[g0]); end
      n_cmp++; if (got[g0+1] !== 16'h5678) begin n_bad++; $display("FAIL rev_second: got %h want 5678", got[g0+1]); end
    end
    n_cmp++;
    if (addrq.size() != a0 + 2 || addrq[a0+1] !== E) begin
      n_bad++; $display("FAIL rev_wrap_addr: reads %0d, second addr %h want %h", addrq.size() - a0, addrq[addrq.size()-1], E);
    end
  endtask

  task automatic test_forward_wrap();
    int g0, a0;
    do_reset();
    mem[7] = 32'hCAFE_BEEF;
    play = 1'b1; reverse = 1'b1;
    restart_pulse();
    reverse = 1'b0;
    g0 = got.size(); a0 = addrq.size();
    tick(); step(10); tick(); step(4); tick(); step(10);
    n_cmp++;
    if (addrq.size() != a0 + 2) begin n_bad++; $display("FAIL fwrap_nreads: got %0d want 2", addrq.size() - a0); end
    else begin
      n_cmp++; if (addrq[a0] !== E) begin n_bad++; $display("FAIL fwrap_addr0: got %h want %h", addrq[a0], E); end
      n_cmp++; if (addrq[a0+1] !== S) begin n_bad++; $display("FAIL fwrap_addr1: got %h want %h", addrq[a0+1], S); end
    end
    n_cmp++;
    if (got.size() < g0 + 2 || got[g0] !== 16'hBEEF || got[g0+1] !== 16'hCAFE) begin
      n_bad++; $display("FAIL fwrap_samples: count %0d want BEEF,CAFE", got.size() - g0);
    end
  endtask

  task automatic test_stall_pause();
    int g0, r0;
    do_reset();
    mem[0] = 32'h0BAD_F00D;
    play = 1'b1; reverse = 1'b0; wait_cfg = 5; lat_cfg = 4;
    g0 = got.size(); r0 = rd_cycles;
    tick();
    wait_read_low();
    play = 1'b0;
    step(15);
    n_cmp++; if (rd_cycles - r0 != 6) begin n_bad++; $display("FAIL stall_read_cycles: got %0d want 6", rd_cycles - r0); end
    n_cmp++;
    if (got.size() != g0 + 1 || got[g0] !== 16'hF00D) begin
      n_bad++; $display("FAIL pause_first: count %0d want 1 sample F00D", got.size() - g0);
    end
    repeat (3) begin tick(); step(5); end
    n_cmp++; if (got.size() != g0 + 1) begin n_bad++; $display("FAIL pause_hold: got %0d samples want 1", got.size() - g0); end
    n_cmp++; if (audio_data !== 16'hF00D) begin n_bad++; $display("FAIL pause_data: got %h want F00D", audio_data); end
    play = 1'b1;
    tick(); step(5);
    n_cmp++;
    if (got.size() != g0 + 2 || got[g0+1] !== 16'h0BAD) begin
      n_bad++; $display("FAIL resume_second: count %0d want 2 ending 0BAD", got.size() - g0);
    end
  endtask

  task automatic test_restart_wait();
    int g0, a0;
    do_reset();
    mem[7] = 32'h7777_1111;
    play = 1'b1; reverse = 1'b1; lat_cfg = 4;
    g0 = got.size(); a0 = addrq.size();
    tick();
    wait_read_low();
    restart_pulse();
    step(12);
    n_cmp++; if (got.size() != g0) begin n_bad++; $display("FAIL restart_novalid: got %0d samples want 0", got.size() - g0); end
    tick(); step(12); tick(); step(4);
    n_cmp++;
    if (addrq.size() != a0 + 2 || addrq[a0+1] !== E) begin
      n_bad++; $display("FAIL restart_addr: reads %0d, last %h want %h", addrq.size() - a0, addrq[addrq.size()-1], E);
    end
    n_cmp++;
    if (got.size() != g0 + 2 || got[g0] !== 16'h7777) begin
      n_bad++; $display("FAIL restart_sample: count %0d want 2 starting 7777", got.size() - g0);
    end
  endtask

  task automatic test_reset_mid();
    int g0;
    do_reset();
    mem[0] = 32'h4444_3333;
    play = 1'b1; reverse = 1'b0;
    tick(); step(10); tick(); step(4);
    wait_cfg = 1000;
    tick(); step(2);
    n_cmp++; if (flash_mem_read !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_read: got %b want 1", flash_mem_read); end
    reset = 1'b0; step(1);
    n_cmp++; if (flash_mem_read !== 1'b0) begin n_bad++; $display("FAIL midrst_read: got %b want 0", flash_mem_read); end
    n_cmp++; if (audio_data !== 16'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0000", audio_data); end
    reset = 1'b1; wait_cfg = 0;
    g0 = got.size();
    @(posedge CLK_50M); inj_req++;
    step(10);
    n_cmp++; if (got.size() != g0) begin n_bad++; $display("FAIL late_rdv: got %0d samples want 0", got.size() - g0); end
    tick(); step(10); tick(); step(4);
    n_cmp++;
    if (got.size() != g0 + 2 || got[g0] !== 16'h3333 || got[g0+1] !== 16'h4444) begin
      n_bad++; $display("FAIL midrst_resume: count %0d want 3333,4444", got.size() - g0);
    end
  endtask

  // Reference: each word is two ticks; direction chosen at the first tick,
  // address walks the region modulo NW, restart jumps to the direction's start.
  task automatic test_random();
    int maddr, g0, a0;
    bit rev;
    logic [15:0] e1, e2;
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    do_reset();
    play = 1'b1; maddr = 0;
    for (int w = 0; w < 24; w++) begin
      rev = 1'($urandom_range(0, 1));
      reverse = rev;
      if ($urandom_range(0, 4) == 0) begin
        restart_pulse();
        maddr = rev ? NW - 1 : 0;
      end
      wait_cfg = $urandom_range(0, 3); lat_cfg = $urandom_range(1, 3);
      g0 = got.size(); a0 = addrq.size();
      tick();
      if ($urandom_range(0, 1) == 1) tick();
      if ($urandom_range(0, 1) == 1) reverse = ~rev;
      step(14); tick(); step(4);
      e1 = rev ? mem[maddr][31:16] : mem[maddr][15:0];
      e2 = rev ? mem[maddr][15:0]  : mem[maddr][31:16];
      n_cmp++;
      if (addrq.size() != a0 + 1 || addrq[a0] !== 23'(maddr)) begin
        n_bad++; $display("FAIL rnd_addr w%0d: reads %0d last %h want %0d", w, addrq.size() - a0, addrq[addrq.size()-1], maddr);
      end
      n_cmp++;
      if (got.size() != g0 + 2) begin n_bad++; $display("FAIL rnd_count w%0d: got %0d want 2", w, got.size() - g0); end
      else if (got[g0] !== e1 || got[g0+1] !== e2) begin
        n_bad++; $display("FAIL rnd_data w%0d: got %h,%h want %h,%h", w, got[g0], got[g0+1], e1, e2);
      end
      maddr = (maddr + (rev ? NW - 1 : 1)) % NW;
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 32'h0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_forward_wrap();
    test_stall_pause();
    test_restart_wait();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (dbl_valid != 0) begin n_bad++; $display("FAIL valid_double: %0d back-to-back pulses want 0", dbl_valid); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
